// File: rtl/ball_sprite.sv
// Bouncing square ball for a VGA pipeline: tracks the beam from H/V reset pulses and
// steps the ball once per frame in blanking. Define BALL_BORDER_EN for a 1-pixel frame.
module ball_sprite #(
  parameter int p_WIDTH     = 640,
  parameter int p_HEIGHT    = 480,
  parameter int p_SIZE      = 8,
  parameter int p_SPEED     = 2,
  parameter int p_FRAME_DIV = 1,
  parameter int p_X0        = 100,
  parameter int p_Y0        = 50
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_HReset,
  input  logic i_VReset,
  input  logic i_VBlank,
  output logic o_Video,
  output logic o_Bounce
);

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;  // POS = right / down

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP_X = 2'd1,
    S_STEP_Y = 2'd2
  } state_e;

  typedef struct packed {
    logic [9:0] pos;
    dir_e       dir;
    logic       flip;
  } axis_t;

  localparam logic [10:0] c_SIZE  = 11'(p_SIZE);
  localparam logic [10:0] c_SPEED = 11'(p_SPEED);
  localparam int          c_CNT_W = (p_FRAME_DIV > 1) ? $clog2(p_FRAME_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(p_FRAME_DIV - 1);

`ifdef BALL_BORDER_EN
  localparam logic [9:0] c_X_LO = 10'd1;
  localparam logic [9:0] c_X_HI = 10'(p_WIDTH - 1 - p_SIZE);
  localparam logic [9:0] c_Y_LO = 10'd1;
  localparam logic [9:0] c_Y_HI = 10'(p_HEIGHT - 1 - p_SIZE);
`else
  localparam logic [9:0] c_X_LO = 10'd0;
  localparam logic [9:0] c_X_HI = 10'(p_WIDTH - p_SIZE);
  localparam logic [9:0] c_Y_LO = 10'd0;
  localparam logic [9:0] c_Y_HI = 10'(p_HEIGHT - p_SIZE);
`endif

  // One axis step with reflection; hi is the largest legal top-left coordinate.
  function automatic axis_t step_axis(input logic [9:0] pos, input dir_e dir,
                                      input logic [9:0] lo, input logic [9:0] hi);
    axis_t       res;
    logic [10:0] fwd;
    res = '{pos: pos, dir: dir, flip: 1'b0};
    fwd = {1'b0, pos} + c_SPEED;
    if (dir == DIR_POS) begin
      if (fwd > {1'b0, hi}) res = '{pos: hi, dir: DIR_NEG, flip: 1'b1};
      else                  res.pos = fwd[9:0];
    end else begin
      if ({1'b0, pos} < {1'b0, lo} + c_SPEED) res = '{pos: lo, dir: DIR_POS, flip: 1'b1};
      else                                    res.pos = pos - c_SPEED[9:0];
    end
    return res;
  endfunction

  logic [9:0]         r_col, r_row, r_bx, r_by;
  dir_e               r_dx, r_dy;
  logic               r_vblank_d, r_bounce;
  logic [c_CNT_W-1:0] r_frame_cnt;
  state_e             r_state, w_state_next;
  logic               w_rise, w_step, w_do_x, w_do_y, w_ball, w_border;
  axis_t              w_x, w_y;

  // NOTE: every always_ff uses non-blocking (<=) so all registers update together
  // from pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      if (i_HReset)              r_col <= '0;
      else if (r_col != 10'h3FF) r_col <= r_col + 10'd1;
      if (i_VReset)                          r_row <= '0;
      else if (i_HReset && r_row != 10'h3FF) r_row <= r_row + 10'd1;
    end
  end

  // Edges arriving mid-step are dropped and do not advance the frame divider.
  assign w_rise = i_VBlank && !r_vblank_d && (r_state == S_IDLE);
  assign w_step = w_rise && (r_frame_cnt == '0);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_vblank_d  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vblank_d <= i_VBlank;
      if (w_rise) r_frame_cnt <= (r_frame_cnt == c_CNT_MAX) ? '0 : r_frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_state_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_next = w_step ? S_STEP_X : S_IDLE;
      S_STEP_X: w_state_next = S_STEP_Y;
      S_STEP_Y: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_do_x = (r_state == S_STEP_X);
    w_do_y = (r_state == S_STEP_Y);
  end

  assign w_x = step_axis(r_bx, r_dx, c_X_LO, c_X_HI);
  assign w_y = step_axis(r_by, r_dy, c_Y_LO, c_Y_HI);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_bx     <= 10'(p_X0);
      r_by     <= 10'(p_Y0);
      r_dx     <= DIR_POS;
      r_dy     <= DIR_POS;
      r_bounce <= 1'b0;
    end else begin
      if (w_do_x) begin
        r_bx <= w_x.pos;
        r_dx <= w_x.dir;
      end
      if (w_do_y) begin
        r_by <= w_y.pos;
        r_dy <= w_y.dir;
      end
      r_bounce <= (w_do_x && w_x.flip) || (w_do_y && w_y.flip);
    end
  end

  assign w_ball = (r_col >= r_bx) && ({1'b0, r_col} < {1'b0, r_bx} + c_SIZE) &&
                  (r_row >= r_by) && ({1'b0, r_row} < {1'b0, r_by} + c_SIZE);

`ifdef BALL_BORDER_EN
  assign w_border = (r_row == 10'd0) || (r_row == 10'(p_HEIGHT - 1)) ||
                    (r_col == 10'd0) || (r_col == 10'(p_WIDTH - 1));
`else
  assign w_border = 1'b0;
`endif

  assign o_Video  = !i_Reset && (w_ball || w_border);
  assign o_Bounce = r_bounce;

endmodule
